// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller: loader owns the single-port IMEM in BOOT,
// fetch and loader share it in RUN with a starvation guard for the loader.
module imem_access_ctrl #(
    parameter int                      PC_LENGTH   = 32,
    parameter int                      INST_LENGTH = 32,
    parameter int                      ADDR_WIDTH  = 18,
    parameter int                      STARVE_MAX  = 4,
    parameter logic [INST_LENGTH-1:0]  NOP_INST    = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [PC_LENGTH-1:0]    if_pc,
    output logic                    if_gnt,
    output logic                    if_valid,
    output logic [INST_LENGTH-1:0]  if_inst,
    output logic                    if_misalign,
    input  logic                    ld_req,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    input  logic [INST_LENGTH-1:0]  ld_data,
    output logic                    ld_gnt,
    input  logic                    ld_done,
    output logic                    boot_done,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [INST_LENGTH-1:0]  mem_wdata,
    input  logic [INST_LENGTH-1:0]  mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    logic [SW-1:0]           starve_cnt_r;
    logic                    pending_r;
    logic [INST_LENGTH-1:0]  inst_hold_r;
    logic                    if_valid_r;
    logic                    if_misalign_r;

    logic                    aligned_s;
    logic                    ld_force_s;
    logic                    if_gnt_s;
    logic                    ld_gnt_s;
    logic                    pc_unused_s;

    assign aligned_s   = (if_pc[1:0] == 2'b00);
    assign ld_force_s  = ld_req && (!if_req || (starve_cnt_r == SW'(STARVE_MAX)));
    assign pc_unused_s = ^{if_pc[PC_LENGTH-1:ADDR_WIDTH+2]};

    // Arbitration: loader only in BOOT; in RUN fetch wins unless loader is forced.
    always_comb begin
        if_gnt_s = 1'b0;
        ld_gnt_s = 1'b0;
        if (state_r == BOOT) begin
            ld_gnt_s = ld_req;
        end else begin
            ld_gnt_s = ld_force_s;
            if_gnt_s = if_req && !ld_force_s;
        end
    end

    // Memory port drive: one operation per cycle, misaligned fetches never touch memory.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {INST_LENGTH{1'b0}};
        if (ld_gnt_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
        end else if (if_gnt_s && aligned_s) begin
            mem_en   = 1'b1;
            mem_addr = if_pc[ADDR_WIDTH+1:2];
        end else begin
            mem_en = 1'b0;
        end
    end

    // Boot sequencing, loader starvation count and fetch response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT;
            starve_cnt_r  <= {SW{1'b0}};
            pending_r     <= 1'b0;
            inst_hold_r   <= {INST_LENGTH{1'b0}};
            if_valid_r    <= 1'b0;
            if_misalign_r <= 1'b0;
        end else begin
            if (state_r == BOOT && ld_done) begin
                state_r <= RUN;
            end else begin
                state_r <= state_r;
            end

            if (state_r == RUN && ld_req && !ld_gnt_s) begin
                if (starve_cnt_r != SW'(STARVE_MAX)) begin
                    starve_cnt_r <= starve_cnt_r + SW'(1);
                end else begin
                    starve_cnt_r <= starve_cnt_r;
                end
            end else begin
                starve_cnt_r <= {SW{1'b0}};
            end

            if_valid_r    <= if_gnt_s;
            if_misalign_r <= if_gnt_s && !aligned_s;
            pending_r     <= if_gnt_s && aligned_s;

            // Capture the read word once it has been presented so if_inst holds it later.
            if (if_gnt_s && !aligned_s) begin
                inst_hold_r <= NOP_INST;
            end else if (pending_r) begin
                inst_hold_r <= mem_rdata;
            end else begin
                inst_hold_r <= inst_hold_r;
            end
        end
    end

    assign if_gnt      = if_gnt_s;
    assign ld_gnt      = ld_gnt_s;
    assign if_valid    = if_valid_r;
    assign if_misalign = if_misalign_r;
    assign if_inst     = pending_r ? mem_rdata : inst_hold_r;
    assign boot_done   = (state_r == RUN);

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Directed bench for imem_access_ctrl with a behavioural reference model and a
// synchronous-read RAM attached to the memory port.
module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst, if_req, ld_req, ld_done;
    logic [31:0] if_pc, ld_data, mem_rdata, if_inst, mem_wdata;
    logic [17:0] ld_addr, mem_addr;
    logic        if_gnt, if_valid, if_misalign, ld_gnt, boot_done, mem_en, mem_we;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [0:1023];

    // Reference model state
    bit          m_run;
    int          m_starve;
    bit          m_valid, m_mis;
    logic [31:0] m_inst;
    logic [31:0] mm [0:1023];

    imem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_pc(if_pc), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_inst(if_inst), .if_misalign(if_misalign),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
        .ld_done(ld_done), .boot_done(boot_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[9:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ld_gnt();
        bit forced = ld_req && (!if_req || m_starve == 4);
        return m_run ? forced : ld_req;
    endfunction

    function automatic bit exp_if_gnt();
        return m_run && if_req && !exp_ld_gnt();
    endfunction

    task automatic compare_all();
        bit el = exp_ld_gnt();
        bit ef = exp_if_gnt();
        bit rd = ef && (if_pc[1:0] == 2'd0);
        check("if_gnt", {31'd0, if_gnt}, {31'd0, ef});
        check("ld_gnt", {31'd0, ld_gnt}, {31'd0, el});
        check("mem_en", {31'd0, mem_en}, {31'd0, el || rd});
        check("mem_we", {31'd0, mem_we}, {31'd0, el});
        if (el) begin
            check("mem_addr_wr", {14'd0, mem_addr}, {14'd0, ld_addr});
            check("mem_wdata", mem_wdata, ld_data);
        end else if (rd) begin
            check("mem_addr_rd", {14'd0, mem_addr}, {14'd0, if_pc[19:2]});
        end
        check("boot_done", {31'd0, boot_done}, {31'd0, m_run});
        check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
        check("if_inst", if_inst, m_inst);
        check("if_misalign", {31'd0, if_misalign}, {31'd0, m_mis});
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_starve = 0; m_valid = 1'b0; m_mis = 1'b0; m_inst = 32'd0;
    endtask

    task automatic tick();
        bit el = exp_ld_gnt();
        bit ef = exp_if_gnt();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_valid = ef;
            if (ef) begin
                if (if_pc[1:0] == 2'd0) begin
                    m_inst = mm[if_pc[11:2]];
                    m_mis  = 1'b0;
                end else begin
                    m_inst = 32'h00000013;
                    m_mis  = 1'b1;
                end
            end else begin
                m_mis = 1'b0;
            end
            if (el) mm[ld_addr[9:0]] = ld_data;
            if (m_run && ld_req && !el) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
            else                        m_starve = 0;
            if (ld_done) m_run = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic ir, input logic [31:0] pc,
                        input logic lr, input logic [17:0] la, input logic [31:0] ldat,
                        input logic dn);
        rst = r; if_req = ir; if_pc = pc; ld_req = lr; ld_addr = la; ld_data = ldat; ld_done = dn;
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 32'd0;
            mm[i]  = 32'd0;
        end
        mem_rdata = 32'd0;
        rst = 1'b1; if_req = 1'b0; if_pc = 32'd0; ld_req = 1'b0;
        ld_addr = 18'd0; ld_data = 32'd0; ld_done = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        step(1'b1, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0); tick();

        // Fetch requests are refused while booting
        step(1'b0, 1'b1, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_boot_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("lit_boot_done0", {31'd0, boot_done}, 32'd0);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_boot_valid", {31'd0, if_valid}, 32'd0);
        tick();

        // Load two words, finish boot, fetch them back to back
        step(1'b0, 1'b0, 32'd0, 1'b1, 18'd0, 32'h00500093, 1'b0);
        check("lit_ld_gnt", {31'd0, ld_gnt}, 32'd1);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b1, 18'd1, 32'h00100113, 1'b0); tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b1); tick();
        step(1'b0, 1'b1, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_run_done", {31'd0, boot_done}, 32'd1);
        check("lit_run_if_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        step(1'b0, 1'b1, 32'd4, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_inst0", if_inst, 32'h00500093);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_inst1", if_inst, 32'h00100113);
        check("lit_valid1", {31'd0, if_valid}, 32'd1);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_hold", if_inst, 32'h00100113);
        tick();

        // Misaligned fetch returns NOP without a memory access
        step(1'b0, 1'b1, 32'h6, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_mis_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_mis_inst", if_inst, 32'h00000013);
        check("lit_mis_flag", {31'd0, if_misalign}, 32'd1);
        tick();

        // Loader starved by continuous fetch gets in on the fifth cycle
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 32'd0, 1'b1, 18'd5, 32'hDEADBEEF, 1'b0);
            check("lit_starve_ld", {31'd0, ld_gnt}, (k == 4) ? 32'd1 : 32'd0);
            check("lit_starve_if", {31'd0, if_gnt}, (k == 4) ? 32'd0 : 32'd1);
            tick();
        end
        step(1'b0, 1'b1, 32'h14, 1'b0, 18'd0, 32'd0, 1'b0); tick();
        step(1'b0, 1'b1, 32'h10000014, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_wrap_addr", {14'd0, mem_addr}, 32'd5);
        check("lit_starve_inst", if_inst, 32'hDEADBEEF);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_wrap_inst", if_inst, 32'hDEADBEEF);
        tick();

        // Write in the same cycle as ld_done
        step(1'b1, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0); tick();
        step(1'b1, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0); tick();
        step(1'b0, 1'b0, 32'd0, 1'b1, 18'd2, 32'hCAFEF00D, 1'b1);
        check("lit_done_ld_gnt", {31'd0, ld_gnt}, 32'd1);
        check("lit_done_pre", {31'd0, boot_done}, 32'd0);
        tick();
        step(1'b0, 1'b1, 32'd8, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_done_post", {31'd0, boot_done}, 32'd1);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_done_inst", if_inst, 32'hCAFEF00D);
        tick();

        // Reset while a fetch is in flight
        step(1'b0, 1'b1, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0); tick();
        step(1'b1, 1'b1, 32'd4, 1'b0, 18'd0, 32'd0, 1'b0); tick();
        step(1'b0, 1'b1, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0);
        check("lit_rst_valid", {31'd0, if_valid}, 32'd0);
        check("lit_rst_boot", {31'd0, boot_done}, 32'd0);
        check("lit_rst_inst", if_inst, 32'd0);
        check("lit_rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        tick();
        step(1'b0, 1'b0, 32'd0, 1'b0, 18'd0, 32'd0, 1'b0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
